// File: rtl/pca_scale_pkg.sv
// ----------------------------------------------------------------------------
// pca_scale_pkg
//  Shared types and helpers for the PCA scaling datapath.
//  - shw_f       : shift-amount width for a given element width ($clog2(w)+1)
//                  so that k = DATA_W itself is representable.
//  - lane_t      : one lane element at the default element width
//  - shamt_t     : shift amount at the default element width
//  - round_mode_e: rounding behaviour of the build, for status reporting.
//  The rounding mode follows the POW2_DIV_ROUND_EN macro, which is evaluated
//  where the lanes are built.
// ----------------------------------------------------------------------------
package pca_scale_pkg;

  function automatic int shw_f(input int dw);
    return $clog2(dw) + 1;
  endfunction

  localparam int DATA_W_DEF = 8;
  localparam int SHW_DEF    = shw_f(DATA_W_DEF);

  typedef logic [DATA_W_DEF-1:0] lane_t;
  typedef logic [SHW_DEF-1:0]    shamt_t;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

endpackage

// File: rtl/pow2_div_lane.sv
// ----------------------------------------------------------------------------
// pow2_div_lane
//  Combinational divide-by-2^k for one lane element.
//  Build option: POW2_DIV_ROUND_EN
//    undefined -> floor (plain shift), sat always 0
//    defined   -> round-half-up for 1 <= k < DATA_W, clamped to the largest
//                 representable value with sat raised on overflow
//  Ports:
//    x   : lane element (two's complement when SIGNED=1)
//    k   : shift amount
//    y   : x / 2^k
//    sat : rounding result was clamped
// ----------------------------------------------------------------------------
module pow2_div_lane import pca_scale_pkg::*; #(
  parameter int DATA_W = 8,
  parameter bit SIGNED = 1'b1,
  localparam int SHW   = shw_f(DATA_W)
) (
  input  logic [DATA_W-1:0] x,
  input  logic [SHW-1:0]    k,
  output logic [DATA_W-1:0] y,
  output logic              sat
);

`ifdef POW2_DIV_ROUND_EN
  localparam round_mode_e MODE = RND_HALF_UP;
`else
  localparam round_mode_e MODE = RND_TRUNC;
`endif

  // Shifts of DATA_W or more leave only sign fill (or zero).
  function automatic logic [DATA_W-1:0] div_trunc(input logic [DATA_W-1:0] v,
                                                  input logic [SHW-1:0]    sh);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    if (sh >= SHW'(DATA_W))
      div_trunc = SIGNED ? {DATA_W{v[DATA_W-1]}} : '0;
    else if (SIGNED)
      div_trunc = sv >>> sh;
    else
      div_trunc = v >> sh;
  endfunction

  // One guard bit above the element absorbs the +2^(k-1) carry.
  function automatic logic [DATA_W:0] round_shift(input logic [DATA_W-1:0] v,
                                                  input logic [SHW-1:0]    sh);
    logic signed [DATA_W:0] ext;
    logic signed [DATA_W:0] half;
    ext  = SIGNED ? {v[DATA_W-1], v} : {1'b0, v};
    half = (DATA_W+1)'(1) << (sh - 1'b1);
    ext  = ext + half;
    round_shift = SIGNED ? (ext >>> sh) : (ext >> sh);
  endfunction

  // Returns {sat, value}. Rounding only moves upward, so overflow clamps to
  // the positive maximum.
  function automatic logic [DATA_W:0] sat_clamp(input logic [DATA_W:0] r);
    logic ovf;
    ovf = SIGNED ? (r[DATA_W] != r[DATA_W-1]) : r[DATA_W];
    if (ovf)
      sat_clamp = {1'b1, (SIGNED ? {1'b0, {(DATA_W-1){1'b1}}} : {DATA_W{1'b1}})};
    else
      sat_clamp = {1'b0, r[DATA_W-1:0]};
  endfunction

  always_comb begin
    y   = div_trunc(x, k);
    sat = 1'b0;
    if (MODE == RND_HALF_UP && k != '0 && k < SHW'(DATA_W))
      {sat, y} = sat_clamp(round_shift(x, k));
  end

endmodule

// File: rtl/pow2_div_stream.sv
// ----------------------------------------------------------------------------
// pow2_div_stream
//  Streaming LANES-wide divide-by-2^k with valid/ready flow control and a
//  2-stage registered pipeline (p1 = lane results, p2 = output register).
//  Build option: POW2_DIV_ROUND_EN selects round-half-up with clamping in
//  every lane; otherwise results are floored and out_sat stays 0.
//  Ports:
//    clk, rst_n          : clock, asynchronous active-low reset
//    in_valid/in_ready   : input handshake
//    in_data             : lane i = in_data[i*DATA_W +: DATA_W]
//    in_shamt            : shift amount k, travels with the beat
//    out_valid/out_ready : output handshake
//    out_data, out_sat   : lane results and per-lane clamp flags
//    beat_cnt            : accepted input beats since reset (wraps)
//    busy                : any pipeline stage holds a beat
// ----------------------------------------------------------------------------
module pow2_div_stream import pca_scale_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter bit SIGNED = 1'b1,
  parameter int CNT_W  = 16,
  localparam int SHW   = shw_f(DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [SHW-1:0]          in_shamt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_sat,
  output logic [CNT_W-1:0]        beat_cnt,
  output logic                    busy
);

  logic                    vld_p1, vld_p2;
  logic                    rdy_p1, rdy_p2;
  logic [LANES*DATA_W-1:0] lane_y, data_p1;
  logic [LANES-1:0]        lane_sat, sat_p1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pow2_div_lane #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED)
    ) u_lane (
      .x   (in_data[i*DATA_W +: DATA_W]),
      .k   (in_shamt),
      .y   (lane_y[i*DATA_W +: DATA_W]),
      .sat (lane_sat[i])
    );
  end

  // A stage can load when it is empty or its contents leave this cycle.
  assign rdy_p2    = ~vld_p2 | out_ready;
  assign rdy_p1    = ~vld_p1 | rdy_p2;
  assign in_ready  = rdy_p1;
  assign out_valid = vld_p2;
  assign busy      = vld_p1 | vld_p2;

  // ---- stage p1: lane results ----
  always_ff @(posedge clk) begin
    if (rdy_p1 && in_valid) begin
      data_p1 <= lane_y;
      sat_p1  <= lane_sat;
    end
  end

  // ---- stage p2: output register, valids, beat counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
      beat_cnt <= '0;
    end else begin
      if (rdy_p1)
        vld_p1 <= in_valid;
      if (rdy_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          out_data <= data_p1;
          out_sat  <= sat_p1;
        end
      end
      if (in_valid && rdy_p1)
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pow2_div_stream.sv
module tb_pow2_div_stream;
  import pca_scale_pkg::*;

  localparam int DW  = 8;
  localparam int LN  = 4;
  localparam int SHW = shw_f(DW);

`ifdef POW2_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [LN*DW-1:0] in_data = '0;
  logic [SHW-1:0]   in_shamt = '0;

  logic             in_ready_s, out_valid_s, busy_s;
  logic [LN*DW-1:0] out_data_s;
  logic [LN-1:0]    out_sat_s;
  logic [15:0]      beat_cnt_s;
  logic             in_ready_u, out_valid_u, busy_u;
  logic [LN*DW-1:0] out_data_u;
  logic [LN-1:0]    out_sat_u;
  logic [3:0]       beat_cnt_u;

  pow2_div_stream #(.DATA_W(DW), .LANES(LN), .SIGNED(1'b1), .CNT_W(16)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_sat(out_sat_s),
    .beat_cnt(beat_cnt_s), .busy(busy_s));

  pow2_div_stream #(.DATA_W(DW), .LANES(LN), .SIGNED(1'b0), .CNT_W(4)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_data(out_data_u), .out_sat(out_sat_u),
    .beat_cnt(beat_cnt_u), .busy(busy_u));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint floordiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] x, input int k,
                                         input bit sgn, output bit sat);
    longint v, p, r, mx;
    v   = sgn ? longint'($signed(x)) : longint'(x);
    p   = longint'(1) << k;
    mx  = sgn ? 127 : 255;
    sat = 1'b0;
    if (ROUND && k >= 1 && k < DW) begin
      r = floordiv(v + p / 2, p);
      if (r > mx) begin
        r = mx;
        sat = 1'b1;
      end
    end else begin
      r = floordiv(v, p);
    end
    return r[7:0];
  endfunction

  typedef struct {
    logic [LN*DW-1:0] u;
    logic [LN*DW-1:0] s;
    logic [LN-1:0]    su;
    logic [LN-1:0]    ss;
  } exp_t;

  function automatic exp_t model(input logic [LN*DW-1:0] d, input logic [SHW-1:0] k);
    exp_t e;
    bit   sat;
    for (int l = 0; l < LN; l++) begin
      e.u[l*DW +: DW] = ref_div(d[l*DW +: DW], int'(k), 1'b0, sat);
      e.su[l] = sat;
      e.s[l*DW +: DW] = ref_div(d[l*DW +: DW], int'(k), 1'b1, sat);
      e.ss[l] = sat;
    end
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  exp_t             q[$];
  int               occ = 0;
  logic [63:0]      acc = '0;
  int               pops = 0;
  bit               prev_stall = 1'b0;
  logic [LN*DW-1:0] prev_ds, prev_du;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      occ = 0;
      acc = '0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_s", in_ready_s, !(occ == 2 && !out_ready));
      chk("in_ready_u", in_ready_u, !(occ == 2 && !out_ready));
      chk("busy", busy_s, occ != 0);
      chk("out_valid_match", out_valid_u, out_valid_s);
      chk("beat_cnt_s", beat_cnt_s, acc[15:0]);
      chk("beat_cnt_u", beat_cnt_u, acc[3:0]);
      if (prev_stall) begin
        chk("stall_valid", out_valid_s, 1);
        chk("stall_hold_s", out_data_s, prev_ds);
        chk("stall_hold_u", out_data_u, prev_du);
      end
      if (out_valid_s && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data_s", out_data_s, e.s);
          chk("data_u", out_data_u, e.u);
          chk("sat_s", out_sat_s, e.ss);
          chk("sat_u", out_sat_u, e.su);
          pops++;
          occ--;
        end
      end
      prev_stall = out_valid_s && !out_ready;
      prev_ds = out_data_s;
      prev_du = out_data_u;
      if (in_valid && in_ready_s) begin
        q.push_back(model(in_data, in_shamt));
        occ++;
        acc = acc + 1;
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]     x;
    logic [SHW-1:0] k;
    logic [7:0]     eu;
    logic [7:0]     es;
  } vec_t;
  vec_t tbl[8];

  // Present one beat from posedge+1; returns after the accepting edge (+1).
  task automatic send_beat(input logic [LN*DW-1:0] d, input logic [SHW-1:0] k);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = k;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready_s) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy_s && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_timeout", busy_s, 0);
  endtask

  initial begin
    int  lat, sent, p0;
    bit  accn, dropped;

    tbl[0] = '{8'hC8, 4'd1, 8'd100, 8'hE4};
    tbl[1] = '{8'hC8, 4'd3, 8'd25,  8'hF9};
    tbl[2] = '{8'hC8, 4'd9, 8'd0,   8'hFF};
    tbl[3] = ROUND ? '{8'hF9, 4'd1, 8'd125, 8'hFD} : '{8'hF9, 4'd1, 8'd124, 8'hFC};
    tbl[4] = ROUND ? '{8'hFF, 4'd1, 8'h80,  8'h00} : '{8'hFF, 4'd1, 8'h7F,  8'hFF};
    tbl[5] = '{8'hFF, 4'd0, 8'hFF, 8'hFF};
    tbl[6] = ROUND ? '{8'h7F, 4'd2, 8'd32, 8'd32} : '{8'h7F, 4'd2, 8'd31, 8'd31};
    tbl[7] = '{8'h80, 4'd8, 8'd0,  8'hFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_s, 0);
    chk("rst_out_data", out_data_s, 0);
    chk("rst_out_sat", out_sat_s, 0);
    chk("rst_beat_cnt", beat_cnt_s, 0);
    chk("rst_busy", busy_s, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready_s, 1);
    out_ready = 1'b1;

    // Table: single beats, latency and lane values
    for (int i = 0; i < 8; i++) begin
      send_beat({LN{tbl[i].x}}, tbl[i].k);
      lat = 0;
      while (!out_valid_s && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("latency", lat, 1);
      for (int l = 0; l < LN; l++) begin
        chk($sformatf("vec%0d_u_lane%0d", i, l), out_data_u[l*DW +: DW], tbl[i].eu);
        chk($sformatf("vec%0d_s_lane%0d", i, l), out_data_s[l*DW +: DW], tbl[i].es);
      end
      chk($sformatf("vec%0d_sat", i), {out_sat_s, out_sat_u}, 0);
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Backpressure: 8 back-to-back beats, out_ready toggling
    p0 = pops;
    sent = 0;
    dropped = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h8040_20F1;
    in_shamt = 4'd1;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      @(negedge clk);
      accn = in_valid && in_ready_s;
      if (!in_ready_s) dropped = 1'b1;
      @(posedge clk);
      #1;
      if (accn) sent++;
      in_valid  = (sent < 8);
      in_data   = in_data + 32'h1357_9BDF;
      in_shamt  = SHW'(sent % 5);
      out_ready = ~out_ready;
    end
    in_valid = 1'b0;
    chk("bp_sent", sent, 8);
    chk("bp_in_ready_dropped", dropped, 1);
    for (int c = 0; c < 40 && busy_s; c++) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_idle();
    chk("bp_beats_out", pops - p0, 8);

    // Random traffic, then asynchronous reset mid-stream
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = $urandom;
      in_shamt  = SHW'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid_s, 0);
    chk("async_rst_beat_cnt", beat_cnt_s, 0);
    chk("async_rst_busy", busy_s, 0);
    chk("async_rst_out_data", out_data_u, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter wrap: 17 accepted beats on the 4-bit counter
    out_ready = 1'b1;
    sent = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && sent < 17; c++) begin
      @(negedge clk);
      accn = in_valid && in_ready_s;
      @(posedge clk);
      #1;
      if (accn) sent++;
      in_valid = (sent < 17);
      in_data  = $urandom;
      in_shamt = SHW'($urandom_range(0, 8));
    end
    in_valid = 1'b0;
    chk("wrap_cnt_u", beat_cnt_u, 1);
    chk("wrap_cnt_s", beat_cnt_s, 17);
    wait_idle();
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
